stopwatch_seg_display: RTL and testbench

//   Downstream display stage of the stopwatch: consumes the four BCD digits

---
 rtl/stopwatch_pkg.sv | 31 +++
 rtl/stopwatch_seg_display_if.sv | 21 ++
 rtl/bcd_to_seg7.sv | 26 ++
 rtl/stopwatch_seg_display.sv | 88 ++++++++
 tb/tb_stopwatch_seg_display.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch constants: active-low 7-segment glyphs and display slot indices.
// Also used by StopWatch and its bench.
package stopwatch_pkg;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [1:0] SLOT_MS = 2'd0;
  localparam logic [1:0] SLOT_S0 = 2'd1;
  localparam logic [1:0] SLOT_S1 = 2'd2;
  localparam logic [1:0] SLOT_M0 = 2'd3;

  typedef struct packed {
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic [3:0] milsec0;
  } digits_t;

endpackage

// File: rtl/stopwatch_seg_display_if.sv
// Digit inputs from StopWatch and the multiplexed 7-segment display outputs.
interface stopwatch_seg_display_if;
  logic [3:0] min0;
  logic [3:0] sec1;
  logic [3:0] sec0;
  logic [3:0] milSec0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  modport master (
    output min0, sec1, sec0, milSec0,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  min0, sec1, sec0, milSec0,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; codes A..F render as a dash.
module bcd_to_seg7
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_seg_display.sv
// Time-multiplexed 4-digit "m.ss.d" display driver; digits are snapshotted once per frame
// so the shown value never tears while the stopwatch counters ripple.
module stopwatch_seg_display
  import stopwatch_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 250,
  parameter bit          BLANK_LZ = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  stopwatch_seg_display_if.slave  bus
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  digits_t       snap_q;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;
  logic          frame_done_q;

  logic       tick;
  logic       boundary;
  logic       blank;
  logic [3:0] digit;
  logic [6:0] seg_dec;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  assign tick     = (presc_q == PRESC_LAST);
  assign boundary = tick && (idx_q == SLOT_M0);

  always_comb begin
    digit = snap_q.milsec0;
    unique case (idx_q)
      SLOT_MS: digit = snap_q.milsec0;
      SLOT_S0: digit = snap_q.sec0;
      SLOT_S1: digit = snap_q.sec1;
      SLOT_M0: digit = snap_q.min0;
      default: digit = snap_q.milsec0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd_i (digit),
    .seg_o (seg_dec)
  );

  // Leading-zero blanking turns the whole min0 slot dark, decimal point included
  always_comb begin
    blank = BLANK_LZ && (idx_q == SLOT_M0) && (snap_q.min0 == 4'd0);
    an_d  = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = blank ? SEG_OFF : seg_dec;
    dp_d  = blank ? 1'b1 : !((idx_q == SLOT_M0) || (idx_q == SLOT_S0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= SLOT_MS;
      snap_q       <= '0;
      an_q         <= 4'b1111;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= tick ? '0 : presc_q + 1'b1;
      if (tick) idx_q <= idx_q + 2'd1;
      if (boundary) begin
        snap_q <= '{min0: bus.min0, sec1: bus.sec1, sec0: bus.sec0, milsec0: bus.milSec0};
      end
      frame_done_q <= boundary;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_stopwatch_seg_display.sv
// Directed bench: two instances (leading-zero blanking on and off) scanned frame by frame.
module tb_stopwatch_seg_display;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] min0 = 4'd3;
  logic [3:0] sec1 = 4'd5;
  logic [3:0] sec0 = 4'd9;
  logic [3:0] milSec0 = 4'd7;

  int n_checks = 0;
  int n_fails  = 0;

  stopwatch_seg_display_if sw_a ();
  stopwatch_seg_display_if sw_b ();

  assign sw_a.min0    = min0;
  assign sw_a.sec1    = sec1;
  assign sw_a.sec0    = sec0;
  assign sw_a.milSec0 = milSec0;
  assign sw_b.min0    = min0;
  assign sw_b.sec1    = sec1;
  assign sw_b.sec0    = sec0;
  assign sw_b.milSec0 = milSec0;

  stopwatch_seg_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (sw_a)
  );

  stopwatch_seg_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (sw_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // One full frame: 16 cycles after a frame_done pulse (or after reset release).
  // Expected {an,seg,dp,frame_done} built from the snapshot digits em/es1/es0/ems.
  // At step chg the inputs switch to the n* values.
  task automatic check_frame(input string name,
                             input logic [3:0] em, input logic [3:0] es1,
                             input logic [3:0] es0, input logic [3:0] ems,
                             input int chg,
                             input logic [3:0] nm, input logic [3:0] ns1,
                             input logic [3:0] ns0, input logic [3:0] nms);
    logic [12:0] got_a, got_b, exp_a, exp_b;
    logic [3:0]  dig, an_e;
    logic        dp_e, fd_e;
    int          slot;
    for (int s = 1; s <= 16; s++) begin
      step();
      if (s == chg) begin
        min0 = nm; sec1 = ns1; sec0 = ns0; milSec0 = nms;
      end
      slot = (s - 1) / 4;
      case (slot)
        0:       dig = ems;
        1:       dig = es0;
        2:       dig = es1;
        default: dig = em;
      endcase
      an_e  = 4'b1111;
      an_e[slot] = 1'b0;
      dp_e  = !(slot == 1 || slot == 3);
      fd_e  = (s == 16);
      exp_b = {an_e, seg_of(dig), dp_e, fd_e};
      if (slot == 3 && em == 4'd0) exp_a = {4'b1111, 7'b1111111, 1'b1, fd_e};
      else                         exp_a = exp_b;
      got_a = {sw_a.an, sw_a.seg, sw_a.dp, sw_a.frame_done};
      got_b = {sw_b.an, sw_b.seg, sw_b.dp, sw_b.frame_done};
      n_checks++;
      if (got_a !== exp_a) begin
        n_fails++;
        $display("FAIL %s blank_on step %0d: got an/seg/dp/fd=%b required %b",
                 name, s, got_a, exp_a);
      end
      n_checks++;
      if (got_b !== exp_b) begin
        n_fails++;
        $display("FAIL %s blank_off step %0d: got an/seg/dp/fd=%b required %b",
                 name, s, got_b, exp_b);
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    logic [12:0] exp_r;
    exp_r = {4'b1111, 7'b1111111, 1'b1, 1'b0};
    n_checks++;
    if ({sw_a.an, sw_a.seg, sw_a.dp, sw_a.frame_done} !== exp_r) begin
      n_fails++;
      $display("FAIL %s blank_on: got %b required %b", name,
               {sw_a.an, sw_a.seg, sw_a.dp, sw_a.frame_done}, exp_r);
    end
    n_checks++;
    if ({sw_b.an, sw_b.seg, sw_b.dp, sw_b.frame_done} !== exp_r) begin
      n_fails++;
      $display("FAIL %s blank_off: got %b required %b", name,
               {sw_b.an, sw_b.seg, sw_b.dp, sw_b.frame_done}, exp_r);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_vals("reset_hold");
    end
  endtask

  task automatic test_release();
    reset = 1'b0;
    check_frame("first_frame_zero", 4'd0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    check_frame("live_frame", 4'd3, 4'd5, 4'd9, 4'd7, 0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic test_snapshot_hold();
    check_frame("hold_sec0", 4'd3, 4'd5, 4'd9, 4'd7, 6, 4'd3, 4'd5, 4'd2, 4'd7);
    check_frame("new_sec0", 4'd3, 4'd5, 4'd2, 4'd7, 0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic test_invalid_bcd();
    check_frame("pre_dash", 4'd3, 4'd5, 4'd2, 4'd7, 1, 4'd3, 4'hC, 4'd2, 4'd7);
    check_frame("dash", 4'd3, 4'hC, 4'd2, 4'd7, 9, 4'd0, 4'd5, 4'd2, 4'd7);
  endtask

  task automatic test_blank();
    check_frame("blank_min0", 4'd0, 4'd5, 4'd2, 4'd7, 0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    check_reset_vals("reset_mid");
    reset = 1'b0;
    check_frame("restart_zero", 4'd0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    check_frame("restart_live", 4'd0, 4'd5, 4'd2, 4'd7, 0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  initial begin
    test_reset();
    test_release();
    test_snapshot_hold();
    test_invalid_bcd();
    test_blank();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
